h2t_bytes_to_packets: RTL and testbench

Converts the raw host-to-trace byte stream into an Avalon-ST packet stream carrying SOP, EOP and an 8-bit channel. The host stream uses in-band control characters. The block sits directly upstream of the host-to-trace channel adapter and drives that adapter's 8-bit in_channel and packet signals. It contains a decode state machine and a one-deep registered output stage.

---
 rtl/h2t_bytes_to_packets.sv | 120 ++++++++++++
 tb/tb_h2t_bytes_to_packets.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/h2t_bytes_to_packets.sv
// Host-to-trace byte stream decoder: strips in-band SOP/EOP/channel/escape
// characters and presents an Avalon-ST packet stream through a one-deep output register.
module h2t_bytes_to_packets #(
  parameter logic [7:0] SOP_CHAR  = 8'h7A,
  parameter logic [7:0] EOP_CHAR  = 8'h7B,
  parameter logic [7:0] CHAN_CHAR = 8'h7C,
  parameter logic [7:0] ESC_CHAR  = 8'h7D
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_channel,
  output logic       out_startofpacket,
  output logic       out_endofpacket
);

  // DEC_CHAN_ESC covers esc_pend and chan_pend both set: the escaped byte is a channel number
  typedef enum logic [1:0] {
    DEC_DATA,
    DEC_ESC,
    DEC_CHAN,
    DEC_CHAN_ESC
  } dec_state_t;

  dec_state_t state, state_nxt;
  logic       sop_pend, sop_nxt;
  logic       eop_pend, eop_nxt;
  logic       accept;
  logic       emit;
  logic [7:0] emit_data;
  logic       chan_load;
  logic [7:0] chan_val;
  logic [7:0] unesc;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign unesc    = in_data ^ 8'h20;

  always_comb begin
    state_nxt = state;
    sop_nxt   = sop_pend;
    eop_nxt   = eop_pend;
    emit      = 1'b0;
    emit_data = in_data;
    chan_load = 1'b0;
    chan_val  = in_data;
    if (accept) begin
      unique case (state)
        DEC_ESC: begin
          emit      = 1'b1;
          emit_data = unesc;
          state_nxt = DEC_DATA;
        end
        DEC_CHAN_ESC: begin
          chan_load = 1'b1;
          chan_val  = unesc;
          state_nxt = DEC_DATA;
        end
        DEC_CHAN: begin
          if (in_data == ESC_CHAR) begin
            state_nxt = DEC_CHAN_ESC;
          end else begin
            chan_load = 1'b1;
            state_nxt = DEC_DATA;
          end
        end
        DEC_DATA: begin
          if (in_data == SOP_CHAR)       sop_nxt   = 1'b1;
          else if (in_data == EOP_CHAR)  eop_nxt   = 1'b1;
          else if (in_data == CHAN_CHAR) state_nxt = DEC_CHAN;
          else if (in_data == ESC_CHAR)  state_nxt = DEC_ESC;
          else                           emit      = 1'b1;
        end
        default: state_nxt = DEC_DATA;
      endcase
      if (emit) begin
        sop_nxt = 1'b0;
        eop_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DEC_DATA;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      sop_pend <= sop_nxt;
      eop_pend <= eop_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_channel       <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else begin
      if (chan_load) out_channel <= chan_val;
      if (emit) begin
        out_valid         <= 1'b1;
        out_data          <= emit_data;
        out_startofpacket <= sop_pend;
        out_endofpacket   <= eop_pend;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h2t_bytes_to_packets.sv
// Scoreboard bench for h2t_bytes_to_packets: a reference decoder pushes expected
// beats on each accepted byte; the monitor compares every presented beat in order.
module tb_h2t_bytes_to_packets;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_channel;
  logic       out_startofpacket;
  logic       out_endofpacket;

  h2t_bytes_to_packets #(
    .SOP_CHAR (8'h7A),
    .EOP_CHAR (8'h7B),
    .CHAN_CHAR(8'h7C),
    .ESC_CHAR (8'h7D)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_channel      (out_channel),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] ch;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned beats  = 0;

  // reference decoder state
  logic       m_sop, m_eop, m_chan, m_esc, lat_pending;
  logic [7:0] m_channel;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_push(input logic [7:0] v);
    beat_t b;
    b.data = v;
    b.ch   = m_channel;
    b.sop  = m_sop;
    b.eop  = m_eop;
    q.push_back(b);
    m_sop = 1'b0;
    m_eop = 1'b0;
    lat_pending = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] v;
    if (m_esc) begin
      v = b ^ 8'h20;
      m_esc = 1'b0;
      if (m_chan) begin
        m_channel = v;
        m_chan = 1'b0;
      end else begin
        model_push(v);
      end
    end else if (m_chan) begin
      if (b == 8'h7D) m_esc = 1'b1;
      else begin
        m_channel = b;
        m_chan = 1'b0;
      end
    end else begin
      case (b)
        8'h7A:   m_sop  = 1'b1;
        8'h7B:   m_eop  = 1'b1;
        8'h7C:   m_chan = 1'b1;
        8'h7D:   m_esc  = 1'b1;
        default: model_push(b);
      endcase
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sop = 1'b0; m_eop = 1'b0; m_chan = 1'b0; m_esc = 1'b0;
      m_channel = 8'h00; lat_pending = 1'b0;
      q.delete();
    end else begin
      if (lat_pending) check_eq("latency_valid", 8'(out_valid), 8'h01);
      lat_pending = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_beat", out_data, 8'hxx);
        end else begin
          check_eq("beat_data", out_data, q[0].data);
          check_eq("beat_channel", out_channel, q[0].ch);
          check_eq("beat_sop", 8'(out_startofpacket), 8'(q[0].sop));
          check_eq("beat_eop", 8'(out_endofpacket), 8'(q[0].eop));
          if (out_ready) begin
            void'(q.pop_front());
            beats++;
          end else begin
            check_eq("stall_in_ready", 8'(in_ready), 8'h00);
          end
        end
      end
      if (in_valid && in_ready) model_byte(in_data);
    end
  end

  task automatic send(input logic [7:0] b);
    bit acc;
    int unsigned n;
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_eq("send_timeout", b, 8'hxx);
    in_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] s[$]);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic drain(input string tag, input int unsigned exp_beats);
    int unsigned n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_drained"}, 8'(q.size()), 8'h00);
    check_eq({tag, "_beats"}, 8'(beats), 8'(exp_beats));
    beats = 0;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    #12;
    check_eq("rst_valid", 8'(out_valid), 8'h00);
    check_eq("rst_channel", out_channel, 8'h00);
    check_eq("rst_in_ready", 8'(in_ready), 8'h01);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    send_list('{8'h7C, 8'h02, 8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33});
    drain("basic", 3);

    send_list('{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5C});
    drain("escape", 3);

    send_list('{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h7B, 8'h44});
    drain("esc_chan", 1);
    check_eq("esc_chan_value", out_channel, 8'h7B);

    fork
      send_list('{8'h7A, 8'h01, 8'h02, 8'h03, 8'h7B, 8'h04});
      begin
        int unsigned n = 0;
        while (!out_valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check_eq("bp_first_seen", 8'(out_valid), 8'h01);
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
          check_eq("bp_held_data", out_data, 8'h01);
          check_eq("bp_in_ready", 8'(in_ready), 8'h00);
        end
        out_ready = 1'b1;
      end
    join
    drain("backpressure", 4);

    send_list('{8'h7C, 8'h01, 8'h7A, 8'hAA, 8'h7B, 8'hBB,
                8'h7C, 8'h05, 8'h7A, 8'hCC, 8'h7B, 8'hDD});
    drain("chan_switch", 4);

    send_list('{8'h7A, 8'h7C});
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst_valid", 8'(out_valid), 8'h00);
    check_eq("arst_data", out_data, 8'h00);
    check_eq("arst_channel", out_channel, 8'h00);
    check_eq("arst_sop", 8'(out_startofpacket), 8'h00);
    check_eq("arst_eop", 8'(out_endofpacket), 8'h00);
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    beats = 0;
    send(8'h55);
    @(negedge clk);
    check_eq("post_rst_data", out_data, 8'h55);
    check_eq("post_rst_sop", 8'(out_startofpacket), 8'h00);
    check_eq("post_rst_channel", out_channel, 8'h00);
    drain("post_reset", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
